// File: rtl/uart_fifo_receiver_if.sv
// Host-side bundle of the oversampling UART receiver:
// serial line, line format, FIFO head and status.
interface uart_fifo_receiver_if #(
  parameter int DEPTH         = 16,
  parameter int DIVISOR_WIDTH = 24
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                     rx;
  logic [1:0]               dataBits;
  logic                     hasParity;
  logic [1:0]               parityMode;
  logic                     extraStopBit;
  logic [DIVISOR_WIDTH-1:0] clockDivisor;
  logic [7:0]               dataOut;
  logic                     parityError;
  logic                     framingError;
  logic                     breakDetected;
  logic                     dataValid;
  logic                     dataReady;
  logic                     overflow;
  logic                     clearOverflow;
  logic [CW-1:0]            fifoCount;

  modport master (
    output rx, dataBits, hasParity,
    output parityMode, extraStopBit,
    output clockDivisor, dataReady,
    output clearOverflow,
    input  dataOut, parityError,
    input  framingError, breakDetected,
    input  dataValid, overflow, fifoCount
  );

  modport slave (
    input  rx, dataBits, hasParity,
    input  parityMode, extraStopBit,
    input  clockDivisor, dataReady,
    input  clearOverflow,
    output dataOut, parityError,
    output framingError, breakDetected,
    output dataValid, overflow, fifoCount
  );
endinterface

// File: rtl/uart_fifo_receiver.sv
// Oversampling UART receiver: 3-sample majority vote,
// false-start rejection, per-character flags, show-ahead FIFO.
module uart_fifo_receiver #(
  parameter int DEPTH         = 16,
  parameter int OVERSAMPLE    = 16,
  parameter int DIVISOR_WIDTH = 24
) (
  input logic                 clk,
  input logic                 rst,
  uart_fifo_receiver_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(OVERSAMPLE) + 1;
  localparam int DW = DIVISOR_WIDTH;
  localparam logic [TW-1:0] L_SAMP0 =
    TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] L_SAMP2 =
    TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] L_BITEND =
    TW'(OVERSAMPLE);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY,
    S_STOP1, S_STOP2, S_PUSH
  } state_t;

  state_t          r_state;
  logic            r_rx_s1;
  logic            r_rx_s2;
  logic            r_rx_s3;
  logic [DW-1:0]   r_div;
  logic [DW-1:0]   r_div_cnt;
  logic [TW-1:0]   r_tick_idx;
  logic [1:0]      r_votes;
  logic [2:0]      r_bit_cnt;
  logic [2:0]      r_last_bit;
  logic            r_has_par;
  logic [1:0]      r_pmode;
  logic            r_stop2;
  logic [7:0]      r_shift;
  logic            r_par_bit;
  logic            r_perr;
  logic            r_ferr;
  logic            r_brk;

  logic [7:0]      r_mem_data [DEPTH];
  logic [2:0]      r_mem_flags [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_ovf;

  logic            w_start;
  logic [DW-1:0]   w_div_eff;
  logic            w_tick;
  logic [TW-1:0]   w_idx_next;
  logic            w_sample;
  logic            w_decide;
  logic            w_bit_end;
  logic            w_bit;
  logic            w_par_exp;
  logic            w_valid;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_do_push;
  logic            w_drop;

  assign w_start   = r_rx_s3 & ~r_rx_s2;
  assign w_div_eff = (bus.clockDivisor == '0) ?
                     DW'(1) : bus.clockDivisor;
  assign w_tick    = (r_div_cnt == r_div - DW'(1));
  assign w_idx_next = r_tick_idx + TW'(1);
  assign w_sample  = w_tick &&
                     (w_idx_next >= L_SAMP0) &&
                     (w_idx_next <= L_SAMP2);
  assign w_decide  = w_tick && (w_idx_next == L_SAMP2);
  assign w_bit_end = w_tick && (w_idx_next == L_BITEND);
  assign w_bit = (r_votes[1] & r_votes[0]) |
                 (r_votes[1] & r_rx_s2) |
                 (r_votes[0] & r_rx_s2);

  // Expected parity bit for the latched mode
  always_comb begin
    w_par_exp = 1'b0;
    unique case (r_pmode)
      2'b01:   w_par_exp = ^r_shift;
      2'b10:   w_par_exp = ~^r_shift;
      2'b11:   w_par_exp = 1'b1;
      default: w_par_exp = 1'b0;
    endcase
  end

  // Two-stage synchroniser plus one history stage for edges
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= bus.rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  // Frame FSM: bit timing, voting, data and flag capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_div      <= DW'(1);
      r_div_cnt  <= '0;
      r_tick_idx <= '0;
      r_votes    <= '0;
      r_bit_cnt  <= '0;
      r_last_bit <= '0;
      r_has_par  <= 1'b0;
      r_pmode    <= '0;
      r_stop2    <= 1'b0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_brk      <= 1'b0;
    end else begin
      if (r_state != S_IDLE && r_state != S_PUSH) begin
        r_div_cnt <= w_tick ? '0 : r_div_cnt + DW'(1);
        if (w_tick)
          r_tick_idx <= w_bit_end ? '0 : w_idx_next;
        if (w_sample)
          r_votes <= {r_votes[0], r_rx_s2};
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state    <= S_START;
            r_div      <= w_div_eff;
            r_div_cnt  <= '0;
            r_tick_idx <= '0;
            r_bit_cnt  <= '0;
            r_last_bit <= {1'b0, bus.dataBits} + 3'd4;
            r_has_par  <= bus.hasParity;
            r_pmode    <= bus.parityMode;
            r_stop2    <= bus.extraStopBit;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_brk      <= 1'b0;
          end
        end
        S_START: begin
          if (w_decide && w_bit)
            r_state <= S_IDLE;
          else if (w_bit_end)
            r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_decide)
            r_shift[r_bit_cnt] <= w_bit;
          if (w_bit_end) begin
            if (r_bit_cnt == r_last_bit)
              r_state <= r_has_par ? S_PARITY : S_STOP1;
            else
              r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end
        S_PARITY: begin
          if (w_decide) begin
            r_par_bit <= w_bit;
            r_perr    <= (w_bit != w_par_exp);
          end
          if (w_bit_end)
            r_state <= S_STOP1;
        end
        S_STOP1: begin
          if (w_decide) begin
            if (!w_bit)
              r_ferr <= 1'b1;
            r_brk <= !w_bit && (r_shift == '0) &&
                     !r_par_bit;
            if (!r_stop2)
              r_state <= S_PUSH;
          end else if (w_bit_end) begin
            r_state <= S_STOP2;
          end
        end
        S_STOP2: begin
          if (w_decide) begin
            if (!w_bit)
              r_ferr <= 1'b1;
            r_state <= S_PUSH;
          end
        end
        S_PUSH: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_valid   = (r_count != '0);
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_push    = (r_state == S_PUSH);
  assign w_pop     = w_valid && bus.dataReady;
  assign w_do_push = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  // FIFO storage; unread slots are masked at the output
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem_data[r_wr_ptr]  <= r_shift;
      r_mem_flags[r_wr_ptr] <= {r_perr, r_ferr, r_brk};
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_do_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_pop)
        r_count <= r_count + (AW+1)'(1);
      else if (!w_do_push && w_pop)
        r_count <= r_count - (AW+1)'(1);
      if (w_drop)
        r_ovf <= 1'b1;
      else if (bus.clearOverflow)
        r_ovf <= 1'b0;
    end
  end

  assign bus.dataValid = w_valid;
  assign bus.dataOut = w_valid ?
    r_mem_data[r_rd_ptr] : 8'h00;
  assign bus.parityError = w_valid &&
    r_mem_flags[r_rd_ptr][2];
  assign bus.framingError = w_valid &&
    r_mem_flags[r_rd_ptr][1];
  assign bus.breakDetected = w_valid &&
    r_mem_flags[r_rd_ptr][0];
  assign bus.overflow  = r_ovf;
  assign bus.fifoCount = r_count;
endmodule

// File: tb/tb_uart_fifo_receiver.sv
// Directed bench for uart_fifo_receiver: vector table
// plus glitch, break, overflow and full push/pop sequences.
module tb_uart_fifo_receiver;
  localparam int DEPTH  = 4;
  localparam int OS     = 16;
  localparam int DIVW   = 24;
  localparam int BITCLK = 160;
  localparam int NV     = 10;

  typedef struct {
    logic [7:0] data;
    logic [1:0] db;
    logic       hp;
    logic [1:0] pm;
    logic       es;
    logic       bad;
    logic       s1;
    logic       s2;
    logic [7:0] e_data;
    logic       e_pe;
    logic       e_fe;
    logic       e_br;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vt [NV];

  always #5 clk = ~clk;

  uart_fifo_receiver_if #(
    .DEPTH(DEPTH), .DIVISOR_WIDTH(DIVW)
  ) bus ();

  uart_fifo_receiver #(
    .DEPTH(DEPTH), .OVERSAMPLE(OS),
    .DIVISOR_WIDTH(DIVW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.rx = b;
    repeat (BITCLK) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input int n,
                            input logic hp,
                            input logic pb,
                            input logic s1,
                            input logic es,
                            input logic s2);
    send_bit(1'b0);
    for (int i = 0; i < n; i++)
      send_bit(d[i]);
    if (hp)
      send_bit(pb);
    send_bit(s1);
    if (es)
      send_bit(s2);
    bus.rx = 1'b1;
  endtask

  task automatic set_cfg(input logic [1:0] db,
                         input logic hp,
                         input logic [1:0] pm,
                         input logic es);
    bus.dataBits     = db;
    bus.hasParity    = hp;
    bus.parityMode   = pm;
    bus.extraStopBit = es;
  endtask

  function automatic logic par_bit(input logic [7:0] d,
                                   input int n,
                                   input logic [1:0] pm);
    logic x;
    x = 1'b0;
    for (int i = 0; i < n; i++)
      x = x ^ d[i];
    case (pm)
      2'b00:   return 1'b0;
      2'b11:   return 1'b1;
      2'b01:   return x;
      default: return ~x;
    endcase
  endfunction

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.dataValid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.dataValid) begin
      checks++;
      errors++;
      $display("FAIL %s: dataValid timeout got 0 expected 1",
               name);
    end
  endtask

  task automatic expect_head(input string name,
                             input logic [7:0] d,
                             input logic pe,
                             input logic fe,
                             input logic br);
    wait_valid(name);
    check({name, " data"}, bus.dataOut, d);
    check({name, " perr"}, bus.parityError, pe);
    check({name, " ferr"}, bus.framingError, fe);
    check({name, " brk"}, bus.breakDetected, br);
  endtask

  task automatic pop(input logic clr);
    align();
    bus.dataReady     = 1'b1;
    bus.clearOverflow = clr;
    align();
    bus.dataReady     = 1'b0;
    bus.clearOverflow = 1'b0;
    @(negedge clk);
  endtask

  task automatic send8(input logic [7:0] d);
    align();
    send_frame(d, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    logic pb;
    int   n;
    vt[0] = '{8'h60, 2'd3, 1'b1, 2'b01, 1'b0, 1'b0,
              1'b1, 1'b1, 8'h60, 1'b0, 1'b0, 1'b0};
    vt[1] = '{8'h55, 2'd2, 1'b1, 2'b10, 1'b0, 1'b1,
              1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
    vt[2] = '{8'hA5, 2'd3, 1'b0, 2'b00, 1'b0, 1'b0,
              1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vt[3] = '{8'h1F, 2'd0, 1'b0, 2'b00, 1'b1, 1'b0,
              1'b1, 1'b0, 8'h1F, 1'b0, 1'b1, 1'b0};
    vt[4] = '{8'hC3, 2'd1, 1'b0, 2'b00, 1'b0, 1'b0,
              1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
    vt[5] = '{8'h81, 2'd3, 1'b1, 2'b11, 1'b0, 1'b0,
              1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0};
    vt[6] = '{8'h7E, 2'd3, 1'b1, 2'b00, 1'b0, 1'b1,
              1'b1, 1'b1, 8'h7E, 1'b1, 1'b0, 1'b0};
    vt[7] = '{8'h40, 2'd3, 1'b0, 2'b00, 1'b0, 1'b0,
              1'b0, 1'b1, 8'h40, 1'b0, 1'b1, 1'b0};
    vt[8] = '{8'h00, 2'd3, 1'b0, 2'b00, 1'b0, 1'b0,
              1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
    vt[9] = '{8'h00, 2'd2, 1'b1, 2'b01, 1'b0, 1'b0,
              1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};

    rst               = 1'b1;
    bus.rx            = 1'b1;
    bus.dataReady     = 1'b0;
    bus.clearOverflow = 1'b0;
    bus.clockDivisor  = 24'd10;
    set_cfg(2'd3, 1'b0, 2'b00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst valid", bus.dataValid, 1'b0);
    check("rst data", bus.dataOut, 8'h00);
    check("rst count", bus.fifoCount, 3'd0);
    check("rst ovf", bus.overflow, 1'b0);
    check("rst flags", {bus.parityError,
          bus.framingError, bus.breakDetected}, 3'b000);

    for (int i = 0; i < NV; i++) begin
      n  = int'(vt[i].db) + 5;
      pb = par_bit(vt[i].data, n, vt[i].pm) ^ vt[i].bad;
      set_cfg(vt[i].db, vt[i].hp, vt[i].pm, vt[i].es);
      align();
      send_frame(vt[i].data, n, vt[i].hp, pb,
                 vt[i].s1, vt[i].es, vt[i].s2);
      expect_head($sformatf("vec%0d", i), vt[i].e_data,
                  vt[i].e_pe, vt[i].e_fe, vt[i].e_br);
      check($sformatf("vec%0d count", i),
            bus.fifoCount, 3'd1);
      pop(1'b0);
      check($sformatf("vec%0d popvalid", i),
            bus.dataValid, 1'b0);
      check($sformatf("vec%0d popdata", i),
            bus.dataOut, 8'h00);
    end

    set_cfg(2'd3, 1'b0, 2'b00, 1'b0);
    align();
    bus.rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    bus.rx = 1'b1;
    repeat (400) @(posedge clk);
    @(negedge clk);
    check("glitch count", bus.fifoCount, 3'd0);
    send8(8'hA5);
    expect_head("post-glitch", 8'hA5, 1'b0, 1'b0, 1'b0);
    pop(1'b0);

    align();
    bus.rx = 1'b0;
    repeat (3200) @(posedge clk);
    #1;
    bus.rx = 1'b1;
    repeat (300) @(posedge clk);
    @(negedge clk);
    check("break count", bus.fifoCount, 3'd1);
    expect_head("break", 8'h00, 1'b0, 1'b1, 1'b1);
    pop(1'b0);
    check("break single", bus.fifoCount, 3'd0);
    send8(8'h3C);
    expect_head("post-break", 8'h3C, 1'b0, 1'b0, 1'b0);
    pop(1'b0);

    for (int k = 1; k <= 5; k++)
      send8(8'(k));
    @(negedge clk);
    check("ovf count", bus.fifoCount, 3'd4);
    check("ovf set", bus.overflow, 1'b1);
    check("ovf head", bus.dataOut, 8'h01);
    pop(1'b1);
    check("ovf clear", bus.overflow, 1'b0);
    check("ovf count3", bus.fifoCount, 3'd3);
    for (int k = 2; k <= 4; k++) begin
      check($sformatf("ovf pop%0d", k),
            bus.dataOut, 8'(k));
      pop(1'b0);
    end
    check("ovf empty", bus.dataValid, 1'b0);

    for (int k = 1; k <= 4; k++)
      send8(8'h10 + 8'(k));
    @(negedge clk);
    check("full count", bus.fifoCount, 3'd4);
    align();
    fork
      send_frame(8'h15, 8, 1'b0, 1'b0, 1'b1,
                 1'b0, 1'b1);
      begin
        repeat (1533) @(posedge clk);
        #1;
        bus.dataReady = 1'b1;
        @(posedge clk);
        #1;
        bus.dataReady = 1'b0;
      end
    join
    @(negedge clk);
    check("pp count", bus.fifoCount, 3'd4);
    check("pp ovf", bus.overflow, 1'b0);
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("pp pop%0d", k),
            bus.dataOut, 8'h10 + 8'(k));
      pop(1'b0);
    end
    check("pp empty", bus.fifoCount, 3'd0);

    send8(8'h77);
    send8(8'h78);
    align();
    rst = 1'b1;
    align();
    rst = 1'b0;
    @(negedge clk);
    check("rst2 count", bus.fifoCount, 3'd0);
    check("rst2 valid", bus.dataValid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_fifo_receiver.md
# uart_fifo_receiver

Oversampling UART receiver with a parametrised receive FIFO. Successor to the single-entry UART receiver: it majority-votes three samples per bit and rejects false starts. It reports parity, framing and break conditions per character, and buffers up to DEPTH characters for the host side. It shares the line-format configuration encoding with the UART transmitter, so the two can be looped back on one configuration bus.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥2
- OVERSAMPLE, 16, ticks per bit; even, ≥4
- DIVISOR_WIDTH, 24, width of clockDivisor
- clk  in  1  sole clock
- rst  in  1  reset, synchronous, active-high
- rx  in  1  serial line, asynchronous, idle high
- dataBits  in  2  data bit count = dataBits + 5
- hasParity  in  1  parity bit present
- parityMode  in  2  00 space, 11 mark, 01 even, 10 odd
- extraStopBit  in  1  two stop bits when 1
- clockDivisor  in  DIVISOR_WIDTH  clk cycles per oversample tick; 0 treated as 1
- dataOut  out  8  head character, zero-padded above the data bit count; 0 when empty
- parityError  out  1  head entry flag
- framingError  out  1  head entry flag
- breakDetected  out  1  head entry flag
- dataValid  out  1  FIFO not empty
- dataReady  in  1  pop head when dataValid && dataReady
- overflow  out  1  sticky: a character was dropped
- clearOverflow  in  1  clears overflow
- fifoCount  out  log2(DEPTH)+1  entries held

## Operation
- rx passes through a 2-FF synchroniser; both stages reset to 1. A start is a 1→0 transition on the synchronised signal, seen in IDLE only.
- On start: configuration inputs are latched for the whole frame, and the tick counter and bit tick index are cleared. A tick occurs when the counter reaches clockDivisor−1; the counter then wraps to 0.
- Bit value: majority of synchronised samples at tick indices OVERSAMPLE/2−1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The decision is taken at tick OVERSAMPLE/2+1. The next bit begins after OVERSAMPLE ticks from the start of the current bit.
- States: IDLE → START → DATA → [PARITY if hasParity] → STOP1 → [STOP2 if extraStopBit] → PUSH → IDLE.
- START: a majority of 1 is a false start → IDLE, nothing pushed.
- DATA: bits are shifted LSB first.
- PARITY: expected value is even = XOR of data bits; odd = its inverse; mark = 1; space = 0. A mismatch sets parityError.
- STOP1/STOP2: a 0 sets framingError. STOP2 is still sampled after a STOP1 error.
- Break: all data bits 0, parity bit 0 if present, and STOP1 0. Sets breakDetected=1 and framingError=1; data is 0.
- PUSH: lasts one cycle and writes {data, flags}.
- Return to IDLE happens at the final stop decision plus one cycle. The edge requirement means a line held low after a break produces no further entries until it goes high, then falls again.
- FIFO is show-ahead: dataOut and the head flags come from the head entry combinationally.
- Push while full and no pop: the entry is dropped and overflow is set. Push and pop in the same cycle while full: both succeed and overflow is unchanged. A pop while empty is ignored.
- clearOverflow clears overflow. If it coincides with a new drop, set wins.
- Read/write pointers wrap modulo DEPTH. fifoCount is 0..DEPTH.

## Timing
- Reset values (rst high at a clk edge): state IDLE; FIFO empty; fifoCount 0; dataValid 0; dataOut 0; all flags 0; overflow 0; synchroniser 1.
- rst mid-frame abandons the frame with no push. rst has priority over every other input.
- Pin to detected start: 2–3 clk.
- Start detection to first sample: OVERSAMPLE/2−1 ticks.
- PUSH cycle P gives dataValid=1 at P+1.
- A pop in cycle Q: the next entry, or dataValid=0, is visible at Q+1.
- Frame length in ticks: OVERSAMPLE × (1 + n + parity + stops). The push falls about OVERSAMPLE/2 ticks before the nominal end of the last stop bit.
- Baud tolerance: approximately ±3% with OVERSAMPLE=16.

## Test plan
- 8E1, clockDivisor=10, OVERSAMPLE=16, data 0x60 at 160 clk/bit → one entry, dataOut=0x60, all flags 0, fifoCount=1. One pop → dataValid=0 next cycle.
- 7O1, data 0x55 sent with a deliberately wrong parity bit → dataOut=0x55, parityError=1, framingError=0.
- rx pulsed low for 40 clk (below half a bit) at 160 clk/bit → no entry; the next valid frame 0xA5 (8N1) is received correctly.
- 8N1, rx held low for 3200 clk, then high → exactly one entry: dataOut=0x00, breakDetected=1, framingError=1. A following frame 0x3C is received normally.
- DEPTH=4, five frames 0x01..0x05 with no pops → fifoCount=4, overflow=1. Pops yield 0x01..0x04. clearOverflow asserted together with the first pop → overflow=0 next cycle.
- 5N2, data 0x1F, second stop bit driven 0 → dataOut=0x1F, framingError=1, breakDetected=0. Full FIFO with push and pop in the same cycle → count unchanged, no overflow.
